// File: rtl/copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : copy_pkg
//  Description : Shared definitions for the copy/fill data mover: controller
//                state encoding and transfer mode values.
//  Contents    : state_t   - IDLE / RUN / WAIT / END, 2-bit encoding
//                MODE_COPY - move beats from source FIFO to destination FIFO
//                MODE_FILL - push the latched pattern, never touch the source
//  Revision    : 1.0 - initial release
// ============================================================================
package copy_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_END  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage : copy_pkg
`default_nettype wire

// File: rtl/xfer_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : xfer_cnt
//  Description : Transfer progress counters. A loadable down-counter tracks
//                the beats still owed, an up-counter reports beats pushed.
//  Ports       : wb_clk_i   in  clock
//                wb_rst_n   in  asynchronous active-low reset
//                load       in  load remaining from len, clear beats_done
//                len        in  beat count to load
//                dec        in  one beat pushed this cycle
//                remaining  out beats still owed
//                beats_done out beats pushed since load
//                last_beat  out remaining == 1
//                zero       out remaining == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module xfer_cnt #(
  parameter int LEN_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             dec,
  output logic [LEN_W-1:0] remaining,
  output logic [LEN_W-1:0] beats_done,
  output logic             last_beat,
  output logic             zero
);

  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_beats_done;

  // load has priority: it only happens in IDLE, where dec is never asserted
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_remaining  <= '0;
      r_beats_done <= '0;
    end else if (load) begin
      r_remaining  <= len;
      r_beats_done <= '0;
    end else if (dec) begin
      r_remaining  <= r_remaining - LEN_W'(1);
      r_beats_done <= r_beats_done + LEN_W'(1);
    end
  end

  assign remaining  = r_remaining;
  assign beats_done = r_beats_done;
  assign last_beat  = (r_remaining == LEN_W'(1));
  assign zero       = (r_remaining == '0);

endmodule : xfer_cnt
`default_nettype wire

// File: rtl/copy_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : copy_fill_engine
//  Description : DMA channel data mover between a first-word-fall-through
//                source FIFO and a destination FIFO. COPY forwards source
//                beats, FILL pushes a latched pattern. Terminates on beat
//                count, on an early source last (flagged err_short) or abort.
//  Ports       : wb_clk_i    in  clock
//                wb_rst_n    in  asynchronous active-low reset
//                start       in  level request, held until m_endn asserts
//                mode        in  0=COPY 1=FILL, sampled with start
//                len         in  beats to move, sampled with start
//                pattern     in  fill data, sampled with start
//                abort       in  stop at the next cycle boundary
//                m_src_getn  out active-low source pop
//                m_src       in  source head data
//                m_src_last  in  source head is the final beat
//                m_src_empty in  source FIFO empty
//                m_dst_putn  out active-low destination push
//                m_dst       out destination data
//                m_dst_last  out marks the final pushed beat
//                m_dst_full  in  destination FIFO full
//                m_endn      out active-low completion, held in END
//                busy        out controller not idle
//                beats_done  out beats pushed this transfer
//                err_short   out COPY ended early on m_src_last
//  Revision    : 1.0 - initial release
// ============================================================================
module copy_fill_engine #(
  parameter int DW    = 64,
  parameter int LEN_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic [DW-1:0]    pattern,
  input  logic             abort,
  output logic             m_src_getn,
  input  logic [DW-1:0]    m_src,
  input  logic             m_src_last,
  input  logic             m_src_empty,
  output logic             m_dst_putn,
  output logic [DW-1:0]    m_dst,
  output logic             m_dst_last,
  input  logic             m_dst_full,
  output logic             m_endn,
  output logic             busy,
  output logic [LEN_W-1:0] beats_done,
  output logic             err_short
);

  import copy_pkg::*;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_mode;
  logic [DW-1:0]    r_pattern;
  logic             r_err_short;

  logic             w_load;
  logic             w_ready;
  logic             w_fire;
  logic             w_last_fire;
  logic             w_last_beat;
  logic             w_zero;
  logic [LEN_W-1:0] w_remaining;

  xfer_cnt #(
    .LEN_W (LEN_W)
  ) u_xfer_cnt (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n   (wb_rst_n),
    .load       (w_load),
    .len        (len),
    .dec        (w_fire),
    .remaining  (w_remaining),
    .beats_done (beats_done),
    .last_beat  (w_last_beat),
    .zero       (w_zero)
  );

  assign w_load  = (r_state == S_IDLE) && start;
  assign w_ready = !m_dst_full && ((r_mode == MODE_FILL) || !m_src_empty);
  // The count guard keeps an exhausted counter from ever pushing an extra beat
  assign w_fire  = (r_state == S_RUN) && w_ready && !abort && !w_zero;
  assign w_last_fire = w_fire &&
                       (w_last_beat || ((r_mode == MODE_COPY) && m_src_last));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_COPY;
      r_pattern   <= '0;
      r_err_short <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_mode      <= mode;
        r_pattern   <= pattern;
        r_err_short <= 1'b0;
      end else if (w_fire && (r_mode == MODE_COPY) && m_src_last && !w_last_beat) begin
        // source packet ended while more than one beat was still owed
        r_err_short <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (len == '0) ? S_END : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_fire) begin
          w_next_state = S_END;
        end else if (abort || w_zero) begin
          w_next_state = S_END;
        end else if (!w_fire) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_next_state = S_END;
        end else if (w_ready) begin
          w_next_state = S_RUN;
        end
      end
      S_END: begin
        if (!start) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign m_dst_putn = !w_fire;
  assign m_src_getn = !(w_fire && (r_mode == MODE_COPY));
  assign m_dst_last = w_last_fire;
  assign m_endn     = (r_state != S_END);
  assign busy       = (r_state != S_IDLE);
  assign err_short  = r_err_short;

  // Source head passes straight through so a push needs no extra cycle;
  // the bus reads zero while idle
  assign m_dst = (r_state == S_IDLE)    ? '0 :
                 (r_mode == MODE_COPY)  ? m_src : r_pattern;

endmodule : copy_fill_engine
`default_nettype wire
